// File: rtl/synth_slot_scheduler.sv
// ============================================================================
// synth_slot_scheduler : slot sequencer, frame-aligned note-event front end,
// per-voice velocity table and velocity-scaled level path.
// Optional feature macro: VEL_CURVE_EN (quadratic velocity curve).
// Revision: 1.0
// ============================================================================
`default_nettype none

module synth_slot_scheduler #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int O_ENVS  = 2,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3,
  parameter int VEL_W   = 8,
  parameter int LVL_W   = 8
) (
  input  logic                       OSC_CLK,
  input  logic                       iRST,
  input  logic                       slot_tick,
  input  logic                       evt_valid,
  output logic                       evt_ready,
  input  logic                       evt_note_on,
  input  logic [V_WIDTH-1:0]         evt_key_adr,
  input  logic [7:0]                 evt_key_val,
  input  logic [VEL_W-1:0]           evt_vel,
  input  logic [VOICES-1:0]          keys_on,
  input  logic [LVL_W-1:0]           level_in,
  output logic [V_WIDTH+E_WIDTH-1:0] slot_idx,
  output logic                       frame_start,
  output logic                       note_apply,
  output logic                       note_apply_dly,
  output logic                       apply_note_on,
  output logic [V_WIDTH-1:0]         apply_key_adr,
  output logic [7:0]                 apply_key_val,
  output logic [VOICES-1:0]          keys_on_q,
  output logic [LVL_W-1:0]           level_out
);

  localparam int                   SLOT_W    = V_WIDTH + E_WIDTH;
  localparam int                   SLOTS     = VOICES * V_OSC * O_ENVS;
  localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam int                   PROD_W    = VEL_W + LVL_W;
  localparam logic [LVL_W-1:0]     LVL_MAX   = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 capture;
  logic                 apply;

  logic                 pend_note_on;
  logic [V_WIDTH-1:0]   pend_key_adr;
  logic [7:0]           pend_key_val;
  logic [VEL_W-1:0]     pend_vel;

  logic [VEL_W-1:0]     vel_tbl [VOICES];
  logic [VEL_W-1:0]     vel_store;
  logic [VEL_W-1:0]     vel_rd;
  logic [PROD_W-1:0]    prod;
  logic [PROD_W-1:0]    prod_shr;

  // frame_start is registered alongside the wrap, so it is high while slot_idx reads 0
  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      slot_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= slot_tick && (slot_idx == SLOT_LAST);
      if (slot_tick) begin
        slot_idx <= (slot_idx == SLOT_LAST) ? '0 : slot_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A capture in a frame_start cycle happens in IDLE, so it waits for the next boundary
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    apply     = 1'b0;
    evt_ready = 1'b0;
    case (state)
      IDLE: begin
        evt_ready = 1'b1;
        if (evt_valid) begin
          capture   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (frame_start) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      pend_note_on   <= 1'b0;
      pend_key_adr   <= '0;
      pend_key_val   <= '0;
      pend_vel       <= '0;
      note_apply     <= 1'b0;
      note_apply_dly <= 1'b0;
      apply_note_on  <= 1'b0;
      apply_key_adr  <= '0;
      apply_key_val  <= '0;
      keys_on_q      <= '0;
    end else begin
      if (capture) begin
        pend_note_on <= evt_note_on;
        pend_key_adr <= evt_key_adr;
        pend_key_val <= evt_key_val;
        pend_vel     <= evt_vel;
      end
      note_apply     <= apply;
      note_apply_dly <= note_apply;
      if (apply) begin
        apply_note_on <= pend_note_on;
        apply_key_adr <= pend_key_adr;
        apply_key_val <= pend_key_val;
      end
      if (frame_start) begin
        keys_on_q <= keys_on;
      end
    end
  end

`ifdef VEL_CURVE_EN
  logic [2*VEL_W-1:0] vel_sq;
  assign vel_sq    = (2*VEL_W)'(pend_vel) * (2*VEL_W)'(pend_vel);
  assign vel_store = (&pend_vel) ? '1 : VEL_W'(vel_sq >> VEL_W);
`else
  assign vel_store = pend_vel;
`endif

  // pend_vel still holds the applied event during the note_apply cycle
  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      for (int i = 0; i < VOICES; i++) begin
        vel_tbl[i] <= '1;
      end
    end else if (note_apply && apply_note_on) begin
      vel_tbl[apply_key_adr] <= vel_store;
    end
  end

  assign vel_rd   = vel_tbl[slot_idx[SLOT_W-1 -: V_WIDTH]];
  assign prod     = PROD_W'(vel_rd) * PROD_W'(level_in);
  assign prod_shr = prod >> (VEL_W - 1);

  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      level_out <= '0;
    end else begin
      level_out <= (prod_shr > PROD_W'(LVL_MAX)) ? LVL_MAX : prod_shr[LVL_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_synth_slot_scheduler.sv
// ============================================================================
// tb_synth_slot_scheduler : scoreboard bench for synth_slot_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_synth_slot_scheduler;

  logic       OSC_CLK;
  logic       iRST;
  logic       slot_tick;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_note_on;
  logic [2:0] evt_key_adr;
  logic [7:0] evt_key_val;
  logic [7:0] evt_vel;
  logic [7:0] keys_on;
  logic [7:0] level_in;
  logic [5:0] slot_idx;
  logic       frame_start;
  logic       note_apply;
  logic       note_apply_dly;
  logic       apply_note_on;
  logic [2:0] apply_key_adr;
  logic [7:0] apply_key_val;
  logic [7:0] keys_on_q;
  logic [7:0] level_out;

  synth_slot_scheduler dut (
    .OSC_CLK        (OSC_CLK),
    .iRST           (iRST),
    .slot_tick      (slot_tick),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_note_on    (evt_note_on),
    .evt_key_adr    (evt_key_adr),
    .evt_key_val    (evt_key_val),
    .evt_vel        (evt_vel),
    .keys_on        (keys_on),
    .level_in       (level_in),
    .slot_idx       (slot_idx),
    .frame_start    (frame_start),
    .note_apply     (note_apply),
    .note_apply_dly (note_apply_dly),
    .apply_note_on  (apply_note_on),
    .apply_key_adr  (apply_key_adr),
    .apply_key_val  (apply_key_val),
    .keys_on_q      (keys_on_q),
    .level_out      (level_out)
  );

  initial OSC_CLK = 1'b0;
  always #5 OSC_CLK = ~OSC_CLK;

  typedef struct {
    logic       note_on;
    logic [2:0] adr;
    logic [7:0] key;
    logic [7:0] vel;
  } evt_t;

  evt_t sb[$];
  int   lq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state, advanced once per clock by cycle()
  logic [5:0] exp_idx   = '0;
  logic       exp_fs    = 1'b0;
  logic       exp_pend  = 1'b0;
  logic       exp_apply = 1'b0;
  logic [7:0] exp_kq    = '0;
  logic [7:0] exp_vel [8];

  function automatic logic [7:0] stored_vel(input logic [7:0] v);
    logic [15:0] sq;
    sq = 16'(v) * 16'(v);
`ifdef VEL_CURVE_EN
    if (v == 8'hFF) return 8'hFF;
    return sq[15:8];
`else
    if (sq == 16'hFFFF) return v;
    return v;
`endif
  endfunction

  function automatic int exp_level(input logic [7:0] v, input logic [7:0] l);
    int p;
    p = (int'(v) * int'(l)) >>> 7;
    return (p > 255) ? 255 : p;
  endfunction

  task automatic cycle();
    logic       rst;
    logic       tick;
    logic       valid;
    logic       fs_now;
    logic       pend_now;
    logic [5:0] idx;
    logic [7:0] kin;
    rst = iRST; tick = slot_tick; valid = evt_valid;
    fs_now = exp_fs; pend_now = exp_pend; idx = exp_idx; kin = keys_on;
    @(posedge OSC_CLK);
    if (rst) begin
      exp_idx = '0; exp_fs = 1'b0; exp_pend = 1'b0; exp_apply = 1'b0; exp_kq = '0;
    end else begin
      exp_fs = tick && (idx == 6'd63);
      if (tick) exp_idx = (idx == 6'd63) ? 6'd0 : idx + 6'd1;
      exp_apply = pend_now && fs_now;
      if (exp_apply) exp_pend = 1'b0;
      else if (!pend_now && valid) exp_pend = 1'b1;
      if (fs_now) exp_kq = kin;
    end
    @(negedge OSC_CLK);
  endtask

  task automatic offer(input logic on, input logic [2:0] adr, input logic [7:0] key,
                       input logic [7:0] vel);
    evt_t e;
    evt_valid = 1'b1; evt_note_on = on; evt_key_adr = adr; evt_key_val = key; evt_vel = vel;
    e.note_on = on; e.adr = adr; e.key = key; e.vel = vel;
    if (!exp_pend) sb.push_back(e);
  endtask

  task automatic run_to_idx(input logic [5:0] target);
    for (int i = 0; i < 70 && exp_idx != target; i++) cycle();
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    total++; if (slot_idx !== 6'd0) begin bad++; $display("FAIL rst_slot_idx got=%0d exp=0", slot_idx); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
    total++; if (note_apply !== 1'b0 || note_apply_dly !== 1'b0) begin bad++; $display("FAIL rst_note_apply got=%b/%b exp=0/0", note_apply, note_apply_dly); end
    total++; if ({apply_note_on, apply_key_adr, apply_key_val} !== 12'd0) begin bad++; $display("FAIL rst_apply_fields got=%b/%0d/%0d exp=0", apply_note_on, apply_key_adr, apply_key_val); end
    total++; if (keys_on_q !== 8'd0) begin bad++; $display("FAIL rst_keys_on_q got=%h exp=00", keys_on_q); end
    total++; if (level_out !== 8'd0) begin bad++; $display("FAIL rst_level_out got=%0d exp=0", level_out); end
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL rst_evt_ready got=%b exp=1", evt_ready); end
    iRST = 1'b0;
    slot_tick = 1'b1;
  endtask

  task automatic test_slot_counter();
    int fs_cnt;
    fs_cnt = 0;
    for (int i = 0; i < 140; i++) begin
      cycle();
      if (frame_start === 1'b1) fs_cnt++;
      total++; if (slot_idx !== exp_idx) begin bad++; $display("FAIL slot_idx cyc=%0d got=%0d exp=%0d", i, slot_idx, exp_idx); end
      total++; if (frame_start !== exp_fs) begin bad++; $display("FAIL frame_start cyc=%0d got=%b exp=%b idx=%0d", i, frame_start, exp_fs, slot_idx); end
    end
    total++; if (fs_cnt != 2) begin bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    run_to_idx(6'd63);
    slot_tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      total++; if (slot_idx !== 6'd63 || frame_start !== 1'b0) begin bad++; $display("FAIL freeze got=%0d/%b exp=63/0", slot_idx, frame_start); end
    end
    slot_tick = 1'b1;
    cycle();
    total++; if (slot_idx !== 6'd0 || frame_start !== 1'b1) begin bad++; $display("FAIL resume_wrap got=%0d/%b exp=0/1", slot_idx, frame_start); end
  endtask

  task automatic test_note_on();
    evt_t e;
    logic got;
    run_to_idx(6'd10);
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL note_on_ready_before got=%b exp=1", evt_ready); end
    offer(1'b1, 3'd3, 8'd60, 8'd100);
    cycle();
    evt_valid = 1'b0;
    total++; if (evt_ready !== 1'b0) begin bad++; $display("FAIL note_on_ready_pend got=%b exp=0", evt_ready); end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle();
      total++; if (note_apply !== exp_apply) begin bad++; $display("FAIL note_on_apply_timing got=%b exp=%b", note_apply, exp_apply); end
      if (exp_apply) begin
        got = 1'b1;
        e = sb.pop_front();
        exp_vel[e.adr] = e.note_on ? stored_vel(e.vel) : exp_vel[e.adr];
        total++; if (apply_note_on !== e.note_on || apply_key_adr !== e.adr || apply_key_val !== e.key) begin
          bad++; $display("FAIL note_on_fields got=%b/%0d/%0d exp=%b/%0d/%0d", apply_note_on, apply_key_adr, apply_key_val, e.note_on, e.adr, e.key);
        end
      end
    end
    if (!got) begin total++; bad++; $display("FAIL note_on_apply_timeout got=none exp=pulse"); end
    cycle();
    total++; if (note_apply_dly !== 1'b1 || note_apply !== 1'b0) begin bad++; $display("FAIL note_apply_dly got=%b/%b exp=1/0", note_apply_dly, note_apply); end
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL note_on_ready_after got=%b exp=1", evt_ready); end
  endtask

  task automatic test_frame_start_event();
    evt_t e;
    int lat;
    for (int i = 0; i < 70 && !exp_fs; i++) cycle();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL fs_event_boundary got=%b exp=1", frame_start); end
    offer(1'b1, 3'd5, 8'd72, 8'd128);
    cycle();
    evt_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 100 && note_apply !== 1'b1; i++) begin
      cycle();
      lat++;
      total++; if (note_apply !== exp_apply) begin bad++; $display("FAIL fs_event_apply_timing got=%b exp=%b", note_apply, exp_apply); end
    end
    total++; if (lat != 65) begin bad++; $display("FAIL fs_event_latency got=%0d exp=65", lat); end
    if (sb.size() == 0) begin total++; bad++; $display("FAIL fs_event_scoreboard got=empty exp=1"); end
    else begin
      e = sb.pop_front();
      if (e.note_on) exp_vel[e.adr] = stored_vel(e.vel);
      total++; if (apply_key_adr !== e.adr || apply_key_val !== e.key) begin bad++; $display("FAIL fs_event_fields got=%0d/%0d exp=%0d/%0d", apply_key_adr, apply_key_val, e.adr, e.key); end
    end
  endtask

  task automatic test_back_pressure(input logic on, input logic [2:0] adr, input logic [7:0] key,
                                    input logic [7:0] vel);
    evt_t e;
    logic got;
    run_to_idx(6'd20);
    offer(on, adr, key, vel);
    cycle();
    offer(1'b1, 3'd6, 8'd90, 8'd10);
    for (int i = 0; i < 5; i++) begin
      total++; if (evt_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", evt_ready); end
      cycle();
    end
    evt_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      if (note_apply === 1'b1 || exp_apply) begin
        got = 1'b1;
        total++; if (note_apply !== exp_apply) begin bad++; $display("FAIL bp_apply_timing got=%b exp=%b", note_apply, exp_apply); end
        e = sb.pop_front();
        if (e.note_on) exp_vel[e.adr] = stored_vel(e.vel);
        total++; if (apply_note_on !== e.note_on || apply_key_adr !== e.adr || apply_key_val !== e.key) begin
          bad++; $display("FAIL bp_fields got=%b/%0d/%0d exp=%b/%0d/%0d", apply_note_on, apply_key_adr, apply_key_val, e.note_on, e.adr, e.key);
        end
      end
    end
    if (!got) begin total++; bad++; $display("FAIL bp_apply_timeout got=none exp=pulse"); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_extra_capture got=%0d exp=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_level();
    logic [2:0] v;
    logic [7:0] lvl;
    int         exp;
    run_to_idx(6'd0);
    for (int i = 0; i < 160; i++) begin
      v = exp_idx[5:3];
      if (v == 3'd0) lvl = exp_idx[0] ? 8'd255 : 8'd64;
      else if (v == 3'd5) lvl = exp_idx[0] ? 8'd100 : 8'd200;
      else lvl = 8'($urandom_range(0, 255));
      level_in = lvl;
      keys_on  = 8'($urandom);
      lq.push_back(exp_level(exp_vel[v], lvl));
      cycle();
      exp = lq.pop_front();
      total++; if (level_out !== 8'(exp)) begin bad++; $display("FAIL level_out voice=%0d lvl=%0d got=%0d exp=%0d", v, lvl, level_out, exp); end
      total++; if (keys_on_q !== exp_kq) begin bad++; $display("FAIL keys_on_q got=%h exp=%h", keys_on_q, exp_kq); end
    end
    level_in = 8'd0;
  endtask

  task automatic test_reset_pending();
    run_to_idx(6'd30);
    offer(1'b1, 3'd3, 8'd61, 8'd20);
    cycle();
    evt_valid = 1'b0;
    cycle(); cycle();
    iRST = 1'b1;
    cycle(); cycle();
    sb.delete();
    for (int i = 0; i < 8; i++) exp_vel[i] = 8'hFF;
    iRST = 1'b0;
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL rst_pend_ready got=%b exp=1", evt_ready); end
    total++; if (slot_idx !== 6'd0) begin bad++; $display("FAIL rst_pend_slot got=%0d exp=0", slot_idx); end
    for (int i = 0; i < 140; i++) begin
      cycle();
      total++; if (note_apply !== 1'b0) begin bad++; $display("FAIL rst_pend_apply cyc=%0d got=%b exp=0", i, note_apply); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_vel[i] = 8'hFF;
    iRST = 1'b1; slot_tick = 1'b0; evt_valid = 1'b0; evt_note_on = 1'b0;
    evt_key_adr = '0; evt_key_val = '0; evt_vel = '0; keys_on = '0; level_in = '0;
    test_reset();
    test_slot_counter();
    test_note_on();
    test_frame_start_event();
    test_back_pressure(1'b1, 3'd2, 8'd50, 8'd128);
    test_back_pressure(1'b0, 3'd2, 8'd50, 8'd7);
    test_level();
    test_reset_pending();
    test_level();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
